// File: rtl/apb_slave_mem_if.sv
// APB completer-side signal bundle for apb_slave_mem.
// PSTRB exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    PSELx;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SLV_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SLV_PSTRB_EN
    output PSTRB,
`endif
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SLV_PSTRB_EN
    input  PSTRB,
`endif
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer with a word-addressed register memory, programmable wait states and
// PSLVERR on out-of-range addresses. Define APB_SLV_PSTRB_EN for byte-lane write strobes.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic           PCLK,
  input  logic           PRESET,
  apb_slave_mem_if.slave apb
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_INIT = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  // Transfer captured in the setup cycle; ACCESS-phase bus changes are ignored.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
`ifdef APB_SLV_PSTRB_EN
    logic [STRB_W-1:0]     strb;
`endif
    logic                  err;
  } req_t;

  state_t                r_state;
  req_t                  r_req;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ready;
  logic                  r_slverr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_setup;
  logic                  w_err_in;
  logic [IDX_W-1:0]      w_idx_in;
  logic [IDX_W-1:0]      w_idx_req;
  logic                  w_commit;

  // Extra MSB so a full 2**ADDR_WIDTH memory never flags an error.
  assign w_setup   = apb.PSELx && !apb.PENABLE;
  assign w_err_in  = ({1'b0, apb.PADDR} >= (ADDR_WIDTH+1)'(MEM_DEPTH));
  assign w_idx_in  = IDX_W'(apb.PADDR);
  assign w_idx_req = IDX_W'(r_req.addr);
  assign w_commit  = apb.PSELx && apb.PENABLE && r_req.write && !r_req.err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= S_IDLE;
      r_req    <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready  <= 1'b0;
          r_slverr <= 1'b0;
          r_rdata  <= '0;
          if (w_setup) begin
            r_req.addr  <= apb.PADDR;
            r_req.write <= apb.PWRITE;
            r_req.wdata <= apb.PWDATA;
`ifdef APB_SLV_PSTRB_EN
            r_req.strb  <= apb.PSTRB;
`endif
            r_req.err   <= w_err_in;
            if (WAIT_STATES == 0) begin
              r_state  <= S_READY;
              r_ready  <= 1'b1;
              r_slverr <= w_err_in;
              r_rdata  <= (!apb.PWRITE && !w_err_in) ? r_mem[w_idx_in] : '0;
            end else begin
              r_cnt   <= CNT_W'(CNT_INIT);
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          r_ready  <= 1'b0;
          r_slverr <= 1'b0;
          r_rdata  <= '0;
          if (!apb.PSELx) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_state  <= S_READY;
            r_ready  <= 1'b1;
            r_slverr <= r_req.err;
            r_rdata  <= (!r_req.write && !r_req.err) ? r_mem[w_idx_req] : '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_READY: begin
          if (w_commit) begin
`ifdef APB_SLV_PSTRB_EN
            for (int b = 0; b < int'(STRB_W); b++) begin
              if (r_req.strb[b]) begin
                r_mem[w_idx_req][b*8 +: 8] <= r_req.wdata[b*8 +: 8];
              end
            end
`else
            r_mem[w_idx_req] <= r_req.wdata;
`endif
          end
          r_ready  <= 1'b0;
          r_slverr <= 1'b0;
          r_rdata  <= '0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_ready  <= 1'b0;
          r_slverr <= 1'b0;
          r_rdata  <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign apb.PRDATA  = r_rdata;
  assign apb.PREADY  = r_ready;
  assign apb.PSLVERR = r_slverr;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- Synthesizable APB slave (completer) RTL: the responder end of the APB bus driven by the team's APB master/bridge DUT.
- Presents a word-addressed register memory with a parameterizable number of wait states, and PSLVERR on out-of-range addresses.
- Plugs into the existing apb_interface signal set (PSELx/PENABLE/PWRITE/PADDR/PWDATA in; PRDATA/PREADY/PSLVERR out), replacing the VIP slave driver in integration runs.

Parameters:
- ADDR_WIDTH, 8, PADDR width; PADDR is a word index (no byte offset).
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be a multiple of 8.
- MEM_DEPTH, 64, number of words; legal range is 1 to 2**ADDR_WIDTH.
- WAIT_STATES, 1, PREADY-low cycles inserted in the ACCESS phase; legal range is 0 to 15.

Ports:
- PCLK  input  1  clock; everything is on its rising edge.
- PRESET  input  1  reset, synchronous, active-high.
- PSELx  input  1  slave select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  word address.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data; registered.
- PREADY  output  1  transfer-complete; registered.
- PSLVERR  output  1  error response; registered; valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1 at an edge): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0, all memory words=0. Reset overrides any transfer in flight; no write is committed.
- FSM states: IDLE, WAIT, READY.
- IDLE, PSELx=1 and PENABLE=0 (setup cycle):
  - Capture PADDR, PWRITE, PWDATA into internal regs.
  - err = (PADDR >= MEM_DEPTH).
  - WAIT_STATES=0: go to READY, set PREADY=1, PSLVERR=err.
  - Otherwise: load counter=WAIT_STATES-1, go to WAIT.
- IDLE, any other input (including PENABLE=1 without a setup cycle): stay in IDLE, outputs hold 0.
- WAIT:
  - PSELx=0: abort to IDLE, no write.
  - Else if counter==0: go to READY, PREADY=1, PSLVERR=err.
  - Else decrement counter.
  - PREADY=0 throughout WAIT.
- PRDATA on entry to READY:
  - Read without error: mem[addr].
  - Error or write: 0.
- READY (completion edge, PSELx=1 and PENABLE=1):
  - Write without error: mem[addr] <= captured PWDATA.
  - Then PREADY=0, PSLVERR=0, PRDATA=0, go to IDLE.
  - Write with error: memory unchanged.
- READY with PSELx=0 (protocol violation): abort to IDLE, no write, outputs cleared.
- Latency: setup cycle, then exactly WAIT_STATES ACCESS cycles with PREADY=0, then one ACCESS cycle with PREADY=1. Total 2+WAIT_STATES cycles per transfer.
- Back-to-back: a setup cycle may directly follow the completion cycle; IDLE accepts it with no bubble.
- Read-after-write to the same address in consecutive transfers returns the new data.
- Captured address/data are used, so changes on PADDR/PWDATA during ACCESS are ignored.

Optional Feature:
- Macro: APB_SLV_PSTRB_EN.
- Defined:
  - Adds input PSTRB, width DATA_WIDTH/8, captured in the setup cycle.
  - On write commit, only byte lanes with PSTRB[i]=1 are updated.
  - PSTRB is ignored for reads.
  - A write with PSTRB=0 completes normally and changes nothing.
- Not defined: no PSTRB port; every write updates the full word.

Test Plan:
- Reset: hold PRESET=1 for 2 cycles, then read addr 0x05 -> PRDATA=0, PSLVERR=0. PREADY is 0 out of reset.
- Write/read, WAIT_STATES=1:
  - Write 0xDEADBEEF to 0x10 -> PREADY=1 in the 3rd cycle after setup start.
  - Read 0x10 -> PRDATA=0xDEADBEEF, PSLVERR=0, 3-cycle transfer.
- Out of range, MEM_DEPTH=64:
  - Write 0xFFFFFFFF to 0x40 -> PSLVERR=1 with PREADY; memory unchanged.
  - Read 0x40 -> PRDATA=0, PSLVERR=1.
- WAIT_STATES=0:
  - Back-to-back writes to 0x00, 0x01, then reads -> each transfer takes 2 cycles, no idle cycle needed.
  - Data 0x11111111/0x22222222 read back correctly.
- Abort and reset mid-transfer (WAIT_STATES=3):
  - Drop PSELx during WAIT of a write of 0xA5A5A5A5 to 0x02 -> no PREADY, mem[0x02] stays 0.
  - Assert PRESET in WAIT -> outputs 0 next cycle.
- PSTRB (APB_SLV_PSTRB_EN defined): write 0x12345678 to 0x03, then 0xAABBCCDD with PSTRB=4'b0101 -> read 0x12BB56DD.
